// File: rtl/mean_3x3_pkg.sv
// mean_3x3_pkg: shared widths, divide-by-9 reciprocal and pipeline latency for mean_3x3.
package mean_3x3_pkg;
  localparam int DATA_W = 8;
  function automatic int sum_w(input int dw);
    return dw + 4;
  endfunction
  // Shift of SUM_W+3 keeps the reciprocal error below 2^-SUM_W, exact for every reachable sum.
  function automatic int div_shift(input int dw);
    return sum_w(dw) + 3;
  endfunction
  function automatic int div_mul(input int dw);
    return ((1 << div_shift(dw)) + 8) / 9;
  endfunction
  localparam int SUM_W     = sum_w(DATA_W);
  localparam int DIV_SHIFT = div_shift(DATA_W);
  localparam int DIV_MUL   = div_mul(DATA_W);
  localparam int LATENCY   = 3;
endpackage

// File: rtl/mean_3x3_add3.sv
// add3: registered three-input unsigned adder producing one row sum.
module add3 #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic [IN_W-1:0]  c,
  output logic [OUT_W-1:0] s
);
  always_ff @(posedge clk)
    s <= rst ? '0 : OUT_W'(a) + OUT_W'(b) + OUT_W'(c);
endmodule

// File: rtl/mean_3x3.sv
// mean_3x3: 3-stage pipelined floor mean of a 3x3 unsigned pixel window.
module mean_3x3 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] p0,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  input  logic [DATA_W-1:0] p4,
  input  logic [DATA_W-1:0] p5,
  input  logic [DATA_W-1:0] p6,
  input  logic [DATA_W-1:0] p7,
  input  logic [DATA_W-1:0] p8,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pixel
);
  import mean_3x3_pkg::*;
  localparam int RW = DATA_W + 2;
  localparam int SW = sum_w(DATA_W);
  localparam int DS = div_shift(DATA_W);
  localparam logic [DS-1:0] MUL = DS'(div_mul(DATA_W));
  logic [RW-1:0]      row [3];
  logic [SW-1:0]      total;
  logic [SW+DS-1:0]   prod;
  logic [LATENCY-1:0] vld;
  add3 #(.IN_W(DATA_W), .OUT_W(RW)) u_row0 (.clk(clk), .rst(rst), .a(p0), .b(p1), .c(p2), .s(row[0]));
  add3 #(.IN_W(DATA_W), .OUT_W(RW)) u_row1 (.clk(clk), .rst(rst), .a(p3), .b(p4), .c(p5), .s(row[1]));
  add3 #(.IN_W(DATA_W), .OUT_W(RW)) u_row2 (.clk(clk), .rst(rst), .a(p6), .b(p7), .c(p8), .s(row[2]));
  assign prod = {{DS{1'b0}}, total} * {{SW{1'b0}}, MUL};
  always_ff @(posedge clk) begin
    total     <= rst ? '0 : SW'(row[0]) + SW'(row[1]) + SW'(row[2]);
    out_pixel <= rst ? '0 : DATA_W'(prod >> DS);
    vld       <= rst ? '0 : {vld[LATENCY-2:0], in_valid};
  end
  assign out_valid = vld[LATENCY-1];
endmodule

// File: tb/tb_mean_3x3.sv
// tb_mean_3x3: scoreboard bench for mean_3x3 with directed windows, sum sweep and reset cases.
module tb_mean_3x3;
  typedef struct { int exp; int c; } item_t;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [0:8][7:0] w = '0;
  logic out_valid;
  logic [7:0] out_pixel;
  int cyc = 0, checks = 0, errors = 0;
  item_t q[$];
  mean_3x3 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .p0(w[0]), .p1(w[1]), .p2(w[2]), .p3(w[3]), .p4(w[4]),
    .p5(w[5]), .p6(w[6]), .p7(w[7]), .p8(w[8]),
    .out_valid(out_valid), .out_pixel(out_pixel)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic send(input logic [0:8][7:0] win, input bit push, input int exp);
    @(posedge clk);
    #1;
    in_valid = 1;
    w = win;
    if (push) q.push_back('{exp, cyc});
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    item_t it;
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pixel %0d at cycle %0d, expected none", out_pixel, cyc);
      end else begin
        it = q.pop_front();
        if (out_pixel !== 8'(it.exp) || cyc != it.c + 3) begin
          errors++;
          $display("FAIL result: got %0d at cycle %0d, expected %0d at cycle %0d", out_pixel, cyc, it.exp, it.c + 3);
        end
      end
    end else if (q.size() != 0 && cyc >= q[0].c + 3) begin
      it = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_output: got none at cycle %0d, expected %0d", cyc, it.exp);
    end
  end
  initial begin
    logic [0:8][7:0] v;
    int s;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1;
    w = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50};
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_pixel", int'(out_pixel), 0);
    send('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 0);
    send('{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 1, 255);
    send('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1, 5);
    send('{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, 1, 1);
    send('{8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255}, 1, 254);
    send('{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 0);
    idle();
    send('{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 1);
    idle();
    idle();
    send('{8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20}, 1, 60);
    send('{8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0}, 1, 44);
    idle();
    for (int t = 0; t <= 2295; t++) begin
      s = t;
      for (int i = 0; i < 9; i++) begin
        v[i] = s > 255 ? 8'd255 : 8'(s);
        s -= int'(v[i]);
      end
      send(v, 1, t / 9);
    end
    idle();
    repeat (5) idle();
    send('{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 0, 0);
    send('{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, 0, 0);
    send('{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, 0, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_valid", int'(out_valid), 0);
    end
    send('{8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38}, 1, 34);
    idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
